div_sched: RTL
==============

Name: div_sched

Overview:
- Front-end controller for the iterative 32x32 divider.
- Buffers divide/remainder requests from issue in a small in-order FIFO and launches them one at a time into the divider.
- Holds the divider's operands stable for the whole operation and captures its result into a tagged output register with valid/ready back-pressure.
- Supports a pipeline flush that kills queued and in-flight work.

Parameters:
DEPTH, 2, request FIFO entries (power of 2, >=2)
TAG_W, 6, width of the ROB tag carried with each request

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  issue presents a request
req_ready  out  1  FIFO can accept (= not full)
req_op  in  2  op[0]=unsigned, op[1]=remainder (00 DIV, 01 DIVU, 10 REM, 11 REMU)
req_op1  in  32  dividend
req_op2  in  32  divisor
req_tag  in  TAG_W  ROB tag
flush  in  1  kill all queued and in-flight requests
div_req  out  1  start pulse to divider
div_op  out  2  op to divider, registered
div_op1  out  32  dividend to divider, registered
div_op2  out  32  divisor to divider, registered
div_done  in  1  divider result valid (held while div_stall)
div_result  in  32  divider result
div_stall  out  1  hold divider in its final state
res_valid  out  1  result register holds a live result
res_ready  in  1  consumer accepts result
res_tag  out  TAG_W  tag of result
res_value  out  32  quotient or remainder

Behaviour:
- Reset (async) values:
  - FIFO empty; req_ready=1.
  - State IDLE.
  - div_req=0; div_op/div_op1/div_op2=0.
  - res_valid=0; res_tag=0; res_value=0; killed flag=0.
- Enqueue: req_valid & req_ready writes the tail. No same-cycle pass-through; a request is issuable one cycle after enqueue.
- Full FIFO: req_ready=0 even if a dequeue occurs that cycle.
- State machine (IDLE, ISSUE, WAIT):
  - IDLE: if FIFO non-empty and no flush, pop head into the issue register (op, op1, op2, tag) -> ISSUE.
  - ISSUE: div_req=1 for exactly this cycle -> WAIT.
  - WAIT: div_req=0; issue register frozen so div_op* stay stable until capture.
- Capture: div_done & (~res_valid | res_ready). On capture:
  - If killed=0: res_value<=div_result, res_tag<=issue tag, res_valid<=1.
  - If killed=1: result discarded; res_valid unaffected by it.
  - Clear killed; next state IDLE.
- div_stall = div_done & ~capture. A killed op is always captured, i.e. drained without stall.
- Result register: res_valid & res_ready with no new capture clears res_valid. Capture and drain in the same cycle replace the result (back-to-back, no bubble).
- Flush:
  - Empties FIFO; a same-cycle enqueue is dropped.
  - Clears res_valid.
  - In ISSUE or WAIT, sets killed=1. The divider cannot abort, so the controller stays in WAIT until div_done, then returns to IDLE.
  - In IDLE, no pop occurs that cycle.
- Ordering: strictly in order; at most one op in the divider.
- Throughput: one op per divider latency plus 2 cycles (IDLE pop, ISSUE pulse).
- Latency: enqueue to res_valid = 1 (FIFO) + 1 (ISSUE) + divider latency + 1 (capture register).

Optional Feature:
DIV_ZERO_BYPASS_EN
- Defined: in IDLE, if head req_op2==0 and the result register is free (~res_valid | res_ready), pop the head and write the result directly without using the divider. Written value: 0xFFFFFFFF for DIV/DIVU, dividend for REM/REMU. Tag taken from the head. State stays IDLE.
- Flush in that cycle suppresses the write.
- Not defined: zero divisors are issued to the divider like any other op.

Test Plan:
- DIVU 100/7, tag 5, res_ready=1 -> one div_req pulse; div_op1/div_op2 stable until done; res_valid with res_value=14, res_tag=5, then div_stall=0.
- DIV -100/7 then REM -100/7 back-to-back -> results 0xFFFFFFF2 then 0xFFFFFFFE, in order, tags preserved.
- res_ready=0 when divider finishes -> div_stall=1 and div_done held; raising res_ready captures with no lost or duplicated result.
- Fill FIFO with DEPTH+1 ops while busy -> req_ready=0 once full; all ops complete in order.
- flush mid-WAIT with 2 queued ops -> FIFO empties; no res_valid for any killed op; next new op (REMU 9/4) returns 1.
- DIV x/0 -> res_value=0xFFFFFFFF; REM 123/0 -> 123. With DIV_ZERO_BYPASS_EN the result arrives 1 cycle after pop with no div_req.

Source files
------------

// File: rtl/div_sched.sv
// div_sched: in-order request FIFO plus launch/capture controller for the iterative 32x32 divider.
// Optional build macro DIV_ZERO_BYPASS_EN answers zero-divisor requests from IDLE without the divider.
module div_sched #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_op1,
    input  logic [31:0]      req_op2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             div_req,
    output logic [1:0]       div_op,
    output logic [31:0]      div_op1,
    output logic [31:0]      div_op2,
    input  logic             div_done,
    input  logic [31:0]      div_result,
    output logic             div_stall,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TAG_W-1:0] res_tag,
    output logic [31:0]      res_value
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]       op_mem  [DEPTH];
    logic [31:0]      op1_mem [DEPTH];
    logic [31:0]      op2_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]       state_q, state_d;
    logic [1:0]       iss_op_q, iss_op_d;
    logic [31:0]      iss_op1_q, iss_op1_d;
    logic [31:0]      iss_op2_q, iss_op2_d;
    logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
    logic             killed_q, killed_d;
    logic             res_valid_q, res_valid_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic [31:0]      res_value_q, res_value_d;

    logic             fifo_empty, fifo_full;
    logic             push, pop, launch, bypass, capture;
    logic [1:0]       head_op;
    logic [31:0]      head_op1, head_op2;
    logic [TAG_W-1:0] head_tag;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign head_op  = op_mem[rd_ptr_q[PTR_W-1:0]];
    assign head_op1 = op1_mem[rd_ptr_q[PTR_W-1:0]];
    assign head_op2 = op2_mem[rd_ptr_q[PTR_W-1:0]];
    assign head_tag = tag_mem[rd_ptr_q[PTR_W-1:0]];

    assign req_ready = ~fifo_full;
    assign push      = req_valid & ~fifo_full & ~flush;

    // A killed op never stalls: its result is discarded, so the register's occupancy is irrelevant.
    assign capture   = (state_q == S_WAIT) & div_done & (~res_valid_q | res_ready | killed_q);
    assign div_stall = div_done & ~capture;

    assign div_req   = (state_q == S_ISSUE);
    assign div_op    = iss_op_q;
    assign div_op1   = iss_op1_q;
    assign div_op2   = iss_op2_q;
    assign res_valid = res_valid_q;
    assign res_tag   = res_tag_q;
    assign res_value = res_value_q;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned and infers a latch.
        state_d     = state_q;
        iss_op_d    = iss_op_q;
        iss_op1_d   = iss_op1_q;
        iss_op2_d   = iss_op2_q;
        iss_tag_d   = iss_tag_q;
        killed_d    = killed_q;
        res_valid_d = res_valid_q;
        res_tag_d   = res_tag_q;
        res_value_d = res_value_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pop         = 1'b0;
        launch      = 1'b0;
        bypass      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !flush) begin
`ifdef DIV_ZERO_BYPASS_EN
                    if (head_op2 == 32'd0) begin
                        bypass = ~res_valid_q | res_ready;
                        pop    = bypass;
                    end else begin
                        pop    = 1'b1;
                        launch = 1'b1;
                    end
`else
                    pop    = 1'b1;
                    launch = 1'b1;
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                if (flush) killed_d = 1'b1;
            end
            S_WAIT: begin
                if (capture) begin
                    state_d  = S_IDLE;
                    killed_d = 1'b0;
                end else if (flush) begin
                    killed_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            state_d   = S_ISSUE;
            iss_op_d  = head_op;
            iss_op1_d = head_op1;
            iss_op2_d = head_op2;
            iss_tag_d = head_tag;
        end

        if (res_valid_q && res_ready) res_valid_d = 1'b0;
        if (capture && !killed_q && !flush) begin
            res_valid_d = 1'b1;
            res_value_d = div_result;
            res_tag_d   = iss_tag_q;
        end
        if (bypass) begin
            res_valid_d = 1'b1;
            res_value_d = head_op[1] ? head_op1 : 32'hFFFF_FFFF;
            res_tag_d   = head_tag;
        end
        if (flush) res_valid_d = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: payload storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q[PTR_W-1:0]]  <= req_op;
            op1_mem[wr_ptr_q[PTR_W-1:0]] <= req_op1;
            op2_mem[wr_ptr_q[PTR_W-1:0]] <= req_op2;
            tag_mem[wr_ptr_q[PTR_W-1:0]] <= req_tag;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_IDLE;
            iss_op_q    <= '0;
            iss_op1_q   <= '0;
            iss_op2_q   <= '0;
            iss_tag_q   <= '0;
            killed_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_value_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            iss_op_q    <= iss_op_d;
            iss_op1_q   <= iss_op1_d;
            iss_op2_q   <= iss_op2_d;
            iss_tag_q   <= iss_tag_d;
            killed_q    <= killed_d;
            res_valid_q <= res_valid_d;
            res_tag_q   <= res_tag_d;
            res_value_q <= res_value_d;
        end
    end

endmodule
